// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage -> MEM/WB signal bundle, plus the freeze line back to hazard control.
// master drives the EX/MEM side; slave is the memory stage itself.
interface mem_stage_if;
    logic        MEM_WB_ENIn;
    logic        MEM_R_ENIn;
    logic        MEM_W_ENIn;
    logic [31:0] ALUResIn;
    logic [31:0] RMValIn;
    logic [3:0]  DestIn;
    logic        WB_ENOut;
    logic        MEM_R_ENOut;
    logic [31:0] ALUResOut;
    logic [31:0] MemDataOut;
    logic [3:0]  DestOut;
    logic        freeze;

    modport master (
        output MEM_WB_ENIn, MEM_R_ENIn, MEM_W_ENIn, ALUResIn, RMValIn, DestIn,
        input  WB_ENOut, MEM_R_ENOut, ALUResOut, MemDataOut, DestOut, freeze
    );

    modport slave (
        input  MEM_WB_ENIn, MEM_R_ENIn, MEM_W_ENIn, ALUResIn, RMValIn, DestIn,
        output WB_ENOut, MEM_R_ENOut, ALUResOut, MemDataOut, DestOut, freeze
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: word-addressed data memory behind a fixed wait-state model.
// Freezes upstream and bubbles MEM/WB until each access reaches its completion cycle.
module mem_stage #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    mem_stage_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WAIT_CYCLES);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mem_q [DEPTH];
    logic               access;
    logic               complete;
    logic               freeze;
    logic [IDX_W-1:0]   idx;

    assign access = bus.MEM_R_ENIn | bus.MEM_W_ENIn;
    // Offset from the base, drop the byte lane, wrap modulo DEPTH.
    assign idx = IDX_W'((bus.ALUResIn - 32'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (access && (WAIT_CYCLES > 0)) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A request vanishing mid-wait is abandoned rather than completed.
                if (!access || (cnt_q >= CNT_LIM)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        freeze   = 1'b0;
        complete = 1'b0;
        if (!rst && access) begin
            case (state_q)
                S_IDLE: begin
                    if (WAIT_CYCLES == 0) complete = 1'b1;
                    else                  freeze   = 1'b1;
                end
                S_WAIT: begin
                    if (cnt_q < CNT_LIM) freeze   = 1'b1;
                    else                 complete = 1'b1;
                end
                default: begin
                    freeze   = 1'b0;
                    complete = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (complete && bus.MEM_W_ENIn) begin
            mem_q[idx] <= bus.RMValIn;
        end
    end

    assign bus.freeze      = freeze;
    assign bus.WB_ENOut    = (rst || freeze) ? 1'b0 : bus.MEM_WB_ENIn;
    assign bus.MEM_R_ENOut = (rst || freeze) ? 1'b0 : bus.MEM_R_ENIn;
    assign bus.MemDataOut  = rst ? 32'h0 : mem_q[idx];
    assign bus.ALUResOut   = bus.ALUResIn;
    assign bus.DestOut     = bus.DestIn;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a 2-wait-state instance and a zero-wait instance sharing clk/rst.
// Load results are queued when issued and compared when the stage reports completion.
module tb_mem_stage;
    logic clk;
    logic rst;

    mem_stage_if bus_a ();
    mem_stage_if bus_b ();

    mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dest;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_a [64];
    int          vectors;
    int          miscompares;

    function automatic int word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'd1024;
        return int'(off[7:2]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.MEM_WB_ENIn = 1'b0;
        bus_a.MEM_R_ENIn  = 1'b0;
        bus_a.MEM_W_ENIn  = 1'b0;
        bus_a.ALUResIn    = 32'h0;
        bus_a.RMValIn     = 32'h0;
        bus_a.DestIn      = 4'h0;
    endtask

    task automatic idle_b();
        bus_b.MEM_WB_ENIn = 1'b0;
        bus_b.MEM_R_ENIn  = 1'b0;
        bus_b.MEM_W_ENIn  = 1'b0;
        bus_b.ALUResIn    = 32'h0;
        bus_b.RMValIn     = 32'h0;
        bus_b.DestIn      = 4'h0;
    endtask

    // One access on the 2-wait instance; returns after the edge that ends completion.
    task automatic do_access_a(input logic [31:0] addr, input logic [31:0] data,
                               input logic rd, input logic wr, input logic wb,
                               input logic [3:0] dest, input int exp_frz, input string tag);
        int   frz;
        bit   done;
        int   w;
        exp_t e;
        frz  = 0;
        done = 1'b0;
        w    = word_idx(addr);
        if (rd) sb_q.push_back('{data: model_a[w], dest: dest});
        bus_a.MEM_R_ENIn  = rd;
        bus_a.MEM_W_ENIn  = wr;
        bus_a.MEM_WB_ENIn = wb;
        bus_a.ALUResIn    = addr;
        bus_a.RMValIn     = data;
        bus_a.DestIn      = dest;
        for (int c = 0; c < 16 && !done; c++) begin
            #1;
            vectors++;
            if (u_a.mem_q[w] !== model_a[w]) begin
                $display("FAIL %s early_write: mem=%h required %h", tag, u_a.mem_q[w], model_a[w]);
                miscompares++;
            end
            if (bus_a.freeze === 1'b1) begin
                frz++;
                vectors++;
                if (bus_a.WB_ENOut !== 1'b0 || bus_a.MEM_R_ENOut !== 1'b0) begin
                    $display("FAIL %s bubble: wb=%b mr=%b required 0 0", tag,
                             bus_a.WB_ENOut, bus_a.MEM_R_ENOut);
                    miscompares++;
                end
            end else begin
                done = 1'b1;
                vectors++;
                if (bus_a.WB_ENOut !== wb || bus_a.MEM_R_ENOut !== rd) begin
                    $display("FAIL %s complete_flags: wb=%b mr=%b required %b %b", tag,
                             bus_a.WB_ENOut, bus_a.MEM_R_ENOut, wb, rd);
                    miscompares++;
                end
                vectors++;
                if (bus_a.DestOut !== dest || bus_a.ALUResOut !== addr) begin
                    $display("FAIL %s passthru: dest=%h alu=%h required %h %h", tag,
                             bus_a.DestOut, bus_a.ALUResOut, dest, addr);
                    miscompares++;
                end
                if (rd) begin
                    e = sb_q.pop_front();
                    vectors++;
                    if (bus_a.MemDataOut !== e.data) begin
                        $display("FAIL %s load_data: got %h required %h", tag, bus_a.MemDataOut, e.data);
                        miscompares++;
                    end
                end
            end
            step();
        end
        if (!done) begin
            $display("FAIL %s timeout: no completion within 16 cycles", tag);
            miscompares++;
        end
        if (wr) model_a[w] = data;
        vectors++;
        if (frz != exp_frz) begin
            $display("FAIL %s freeze_cycles: got %0d required %0d", tag, frz, exp_frz);
            miscompares++;
        end
        vectors++;
        if (u_a.mem_q[w] !== model_a[w]) begin
            $display("FAIL %s commit: mem=%h required %h", tag, u_a.mem_q[w], model_a[w]);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.MEM_WB_ENIn = 1'b1;
        bus_a.MEM_R_ENIn  = 1'b1;
        bus_a.MEM_W_ENIn  = 1'b0;
        bus_a.ALUResIn    = 32'd1024;
        step();
        step();
        vectors++;
        if (bus_a.freeze !== 1'b0 || bus_a.WB_ENOut !== 1'b0 || bus_a.MEM_R_ENOut !== 1'b0) begin
            $display("FAIL reset_ctrl: frz=%b wb=%b mr=%b required 0 0 0",
                     bus_a.freeze, bus_a.WB_ENOut, bus_a.MEM_R_ENOut);
            miscompares++;
        end
        vectors++;
        if (bus_a.MemDataOut !== 32'h0) begin
            $display("FAIL reset_memdata: got %h required 00000000", bus_a.MemDataOut);
            miscompares++;
        end
        vectors++;
        if (u_a.state_q !== u_a.S_IDLE || u_a.cnt_q !== 2'd0) begin
            $display("FAIL reset_fsm: state=%0d cnt=%0d required 0 0", u_a.state_q, u_a.cnt_q);
            miscompares++;
        end
        idle_a();
        rst = 1'b0;
        step();
    endtask

    task automatic test_store_load();
        do_access_a(32'd1028, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 4'd0, 2, "store1028");
        do_access_a(32'd1028, 32'h0,        1'b1, 1'b0, 1'b1, 4'd5, 2, "load1028");
        idle_a();
        step();
    endtask

    task automatic test_nonmem();
        bus_a.MEM_WB_ENIn = 1'b1;
        bus_a.ALUResIn    = 32'hDEADBEEF;
        bus_a.DestIn      = 4'd9;
        #1;
        vectors++;
        if (bus_a.freeze !== 1'b0 || bus_a.WB_ENOut !== 1'b1 || bus_a.MEM_R_ENOut !== 1'b0) begin
            $display("FAIL nonmem_flags: frz=%b wb=%b mr=%b required 0 1 0",
                     bus_a.freeze, bus_a.WB_ENOut, bus_a.MEM_R_ENOut);
            miscompares++;
        end
        vectors++;
        if (bus_a.ALUResOut !== 32'hDEADBEEF || bus_a.DestOut !== 4'd9) begin
            $display("FAIL nonmem_passthru: alu=%h dest=%h required deadbeef 9",
                     bus_a.ALUResOut, bus_a.DestOut);
            miscompares++;
        end
        step();
        idle_a();
        step();
    endtask

    task automatic test_wrap();
        do_access_a(32'd1280, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 4'd0, 2, "store1280");
        do_access_a(32'd1024, 32'h0,        1'b1, 1'b0, 1'b1, 4'd3, 2, "load1024_wrap");
        do_access_a(32'd1276, 32'h5A5A0001, 1'b0, 1'b1, 1'b0, 4'd0, 2, "store1276");
        do_access_a(32'd1020, 32'h0,        1'b1, 1'b0, 1'b1, 4'd4, 2, "load1020_below");
        do_access_a(32'd1027, 32'h0,        1'b1, 1'b0, 1'b1, 4'd6, 2, "load1027_lowbits");
        idle_a();
        step();
    endtask

    task automatic test_back_to_back();
        do_access_a(32'd1040, 32'h00000011, 1'b0, 1'b1, 1'b0, 4'd0, 2, "b2b_store");
        do_access_a(32'd1040, 32'h0,        1'b1, 1'b0, 1'b1, 4'd7, 2, "b2b_load");
        do_access_a(32'd1044, 32'h00000077, 1'b1, 1'b1, 1'b1, 4'd8, 2, "rw_both");
        do_access_a(32'd1044, 32'h0,        1'b1, 1'b0, 1'b1, 4'd8, 2, "rw_both_load");
        idle_a();
        step();
    endtask

    task automatic test_reset_mid();
        bus_a.MEM_W_ENIn = 1'b1;
        bus_a.ALUResIn   = 32'd1032;
        bus_a.RMValIn    = 32'hFFFFFFFF;
        #1;
        vectors++;
        if (bus_a.freeze !== 1'b1) begin
            $display("FAIL rstmid_frz1: got %b required 1", bus_a.freeze);
            miscompares++;
        end
        step();
        #1;
        vectors++;
        if (bus_a.freeze !== 1'b1) begin
            $display("FAIL rstmid_frz2: got %b required 1", bus_a.freeze);
            miscompares++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus_a.freeze !== 1'b0) begin
            $display("FAIL rstmid_frz_rst: got %b required 0", bus_a.freeze);
            miscompares++;
        end
        step();
        rst = 1'b0;
        idle_a();
        for (int i = 0; i < 64; i++) model_a[i] = 32'h0;
        #1;
        vectors++;
        if (bus_a.freeze !== 1'b0) begin
            $display("FAIL rstmid_frz_after: got %b required 0", bus_a.freeze);
            miscompares++;
        end
        step();
        do_access_a(32'd1032, 32'h0, 1'b1, 1'b0, 1'b1, 4'd2, 2, "rstmid_load1032");
        do_access_a(32'd1028, 32'h0, 1'b1, 1'b0, 1'b1, 4'd2, 2, "rstmid_load1028");
        idle_a();
        step();
    endtask

    task automatic test_wait0();
        exp_t e;
        bus_b.MEM_W_ENIn = 1'b1;
        bus_b.ALUResIn   = 32'd1036;
        bus_b.RMValIn    = 32'hCAFEF00D;
        #1;
        vectors++;
        if (bus_b.freeze !== 1'b0) begin
            $display("FAIL w0_store_frz: got %b required 0", bus_b.freeze);
            miscompares++;
        end
        vectors++;
        if (u_b.mem_q[3] !== 32'h0) begin
            $display("FAIL w0_early_write: mem=%h required 00000000", u_b.mem_q[3]);
            miscompares++;
        end
        step();
        sb_q.push_back('{data: 32'hCAFEF00D, dest: 4'd11});
        bus_b.MEM_W_ENIn  = 1'b0;
        bus_b.MEM_R_ENIn  = 1'b1;
        bus_b.MEM_WB_ENIn = 1'b1;
        bus_b.DestIn      = 4'd11;
        #1;
        e = sb_q.pop_front();
        vectors++;
        if (bus_b.freeze !== 1'b0 || bus_b.WB_ENOut !== 1'b1 || bus_b.MEM_R_ENOut !== 1'b1) begin
            $display("FAIL w0_load_flags: frz=%b wb=%b mr=%b required 0 1 1",
                     bus_b.freeze, bus_b.WB_ENOut, bus_b.MEM_R_ENOut);
            miscompares++;
        end
        vectors++;
        if (bus_b.MemDataOut !== e.data || bus_b.DestOut !== e.dest) begin
            $display("FAIL w0_load_data: got %h/%h required %h/%h",
                     bus_b.MemDataOut, bus_b.DestOut, e.data, e.dest);
            miscompares++;
        end
        step();
        idle_b();
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) model_a[i] = 32'h0;
        idle_a();
        idle_b();
        rst = 1'b1;
        #1;
        test_reset();
        test_store_load();
        test_nonmem();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_wait0();
        vectors++;
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
